// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: opcodes, fetch FSM states, queue entry type and immediate decoders
package inst_fetcher_pkg;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        jump;
    } iq_entry_t;

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction
endpackage

// File: rtl/inst_fetcher_bht.sv
// bht_predictor: table of 2-bit saturating counters, combinational lookup, synchronous update
module bht_predictor #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);
    logic [1:0] ctr [2**IDX_W];
    logic [1:0] cur;

    assign rd_taken = ctr[rd_idx][1];
    assign cur      = ctr[upd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= 2'b01;
        end else if (rdy && upd_valid) begin
            ctr[upd_idx] <= upd_taken ? (cur == 2'b11 ? 2'b11 : cur + 2'b01)
                                      : (cur == 2'b00 ? 2'b00 : cur - 2'b01);
        end
    end
endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: icache fetch FSM, next-PC prediction and instruction queue.
// Define BHT_PREDICT_EN to predict conditional branches with a 2-bit BHT.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int          IQ_DEPTH_LOG = 4,
    parameter int          BHT_IDX_W    = 8,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        wrong_commit,
    input  logic [31:0] commit_pc,
    input  logic        bp_upd_valid,
    input  logic [31:0] bp_upd_pc,
    input  logic        bp_upd_taken,
    output logic        ic_req_valid,
    output logic [31:0] ic_req_addr,
    input  logic        ic_resp_valid,
    input  logic [31:0] ic_resp_inst,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_jump,
    input  logic        issue_stall
);
    typedef logic [IQ_DEPTH_LOG:0] cnt_t;

    state_t                  state;
    logic [31:0]             pc;
    iq_entry_t               iq [2**IQ_DEPTH_LOG];
    iq_entry_t               head_e;
    logic [IQ_DEPTH_LOG-1:0] head, tail;
    cnt_t                    count;
    logic                    push, pop, br_taken, pred_taken;
    logic [6:0]              op;
    logic [31:0]             next_pc;

`ifdef BHT_PREDICT_EN
    logic unused_bp_pc;
    assign unused_bp_pc = ^{bp_upd_pc[31:BHT_IDX_W+2], bp_upd_pc[1:0]};
    bht_predictor #(.IDX_W(BHT_IDX_W)) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rd_idx    (pc[BHT_IDX_W+1:2]),
        .rd_taken  (br_taken),
        .upd_valid (bp_upd_valid),
        .upd_idx   (bp_upd_pc[BHT_IDX_W+1:2]),
        .upd_taken (bp_upd_taken)
    );
`else
    logic unused_bp;
    assign unused_bp = ^{bp_upd_valid, bp_upd_pc, bp_upd_taken};
    assign br_taken  = 1'b0;
`endif

    assign op         = ic_resp_inst[6:0];
    assign pred_taken = op == OP_JAL || (op == OP_BR && br_taken);
    assign next_pc    = op == OP_JAL ? pc + imm_j(ic_resp_inst)
                      : pred_taken   ? pc + imm_b(ic_resp_inst)
                      :                pc + 32'd4;

    assign push     = rdy && !wrong_commit && state == WAIT && ic_resp_valid;
    assign pop      = rdy && if_valid && !issue_stall && !wrong_commit;
    assign if_valid = count != '0;
    assign head_e   = if_valid ? iq[head] : '0;
    assign if_inst  = head_e.inst;
    assign if_pc    = head_e.pc;
    assign if_jump  = head_e.jump;

    always_ff @(posedge clk) begin
        if (push) iq[tail] <= '{inst: ic_resp_inst, pc: pc, jump: pred_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ic_req_valid <= 1'b0;
            ic_req_addr  <= '0;
        end else if (rdy) begin
            ic_req_valid <= 1'b0;
            if (wrong_commit) begin
                pc    <= commit_pc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
                state <= (state != IDLE && !ic_resp_valid) ? DROP : IDLE;
            end else begin
                // request is decided on the pre-pop occupancy
                if (state == IDLE && !count[IQ_DEPTH_LOG]) begin
                    ic_req_valid <= 1'b1;
                    ic_req_addr  <= pc;
                    state        <= WAIT;
                end
                if (state == DROP && ic_resp_valid) state <= IDLE;
                if (push) begin
                    tail  <= tail + 1'b1;
                    pc    <= next_pc;
                    state <= IDLE;
                end
                if (pop) head <= head + 1'b1;
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: randomized program image checked against an untimed program-order model
module tb_inst_fetcher;
    logic        clk = 1'b0;
    logic        rst, rdy, wrong_commit, bp_upd_valid, bp_upd_taken, issue_stall;
    logic [31:0] commit_pc, bp_upd_pc;
    logic        ic_req_valid, ic_resp_valid, if_valid, if_jump;
    logic [31:0] ic_req_addr, ic_resp_inst, if_inst, if_pc;

    always #5 clk = ~clk;

    inst_fetcher dut (
        .clk(clk), .rst(rst), .rdy(rdy), .wrong_commit(wrong_commit), .commit_pc(commit_pc),
        .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_jump(if_jump),
        .issue_stall(issue_stall)
    );

    // program image: 64 words aliased over the address space; kind 0 plain, 1 JAL, 2 branch
    logic [31:0] mem [64];
    int          kind [64];
    int          off [64];

    // one-cycle-latency icache sharing rdy and rst with the fetcher
    initial ic_resp_inst = 32'h0;
    always @(posedge clk) begin
        if (rst) ic_resp_valid <= 1'b0;
        else if (rdy) begin
            ic_resp_valid <= ic_req_valid;
            ic_resp_inst  <= mem[ic_req_addr[7:2]];
        end
    end

    int          ctr [256];
    logic [31:0] e_pc [256];
    logic [31:0] e_inst [256];
    logic        e_jump [256];
    int          req_idx, pop_idx, tests, fails;

    function automatic logic [31:0] enc_j(input int o);
        logic [31:0] v = o;
        return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_b(input int o);
        logic [31:0] v = o;
        return {v[12], v[10:5], 5'd0, 5'd0, 3'd0, v[4:1], v[11], 7'h63};
    endfunction

    function automatic bit bht_taken(input logic [31:0] p);
`ifdef BHT_PREDICT_EN
        return ctr[p[9:2]] >= 2;
`else
        return p[0] && !p[0];
`endif
    endfunction

    function automatic void bht_update(input logic [31:0] p, input bit t);
        int k = int'(p[9:2]);
        ctr[k] = t ? (ctr[k] < 3 ? ctr[k] + 1 : 3) : (ctr[k] > 0 ? ctr[k] - 1 : 0);
    endfunction

    // expected fetch stream in program order from a start PC
    function automatic void reset_model(input logic [31:0] start);
        logic [31:0] p = start;
        for (int i = 0; i < 256; i++) begin
            int k = int'(p[7:2]);
            bit t = kind[k] == 1 || (kind[k] == 2 && bht_taken(p));
            e_pc[i]   = p;
            e_inst[i] = mem[k];
            e_jump[i] = t;
            p         = t ? p + off[k] : p + 32'd4;
        end
        req_idx = 0;
        pop_idx = 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst && rdy && ic_req_valid && req_idx < 256) begin
            chk("req_addr", ic_req_addr, e_pc[req_idx]);
            req_idx++;
        end
        if (!rst && rdy && if_valid && !issue_stall && !wrong_commit && pop_idx < 256) begin
            chk("head_pc", if_pc, e_pc[pop_idx]);
            chk("head_inst", if_inst, e_inst[pop_idx]);
            chk("head_jump", if_jump, e_jump[pop_idx]);
            pop_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_pops(input int n, input int bound, input bit rnd);
        int target = pop_idx + n;
        int cyc = 0;
        while (pop_idx < target && cyc < bound) begin
            if (rnd) begin
                issue_stall = $urandom_range(0, 9) < 3;
                rdy         = $urandom_range(0, 9) != 0;
            end
            step();
            cyc++;
        end
        rdy         = 1'b1;
        issue_stall = 1'b0;
        chk("pop_timeout", pop_idx >= target, 1);
    endtask

    task automatic wait_req(input string tag);
        int cyc = 0;
        while (!ic_req_valid && cyc < 100) begin
            step();
            cyc++;
        end
        chk(tag, ic_req_valid, 1);
    endtask

    initial begin
        int p0;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 256; i++) ctr[i] = 1;
        for (int i = 0; i < 64; i++) begin
            int r = int'($urandom_range(0, 9));
            int o = (int'($urandom_range(0, 32)) - 16) * 4;
            if (o == 0) o = 4;
            kind[i] = r < 5 ? 0 : r < 6 ? 0 : r < 8 ? 1 : 2;
            off[i]  = kind[i] == 0 ? 0 : o;
            mem[i]  = r < 5 ? {$urandom_range(0, 4095), 5'd1, 3'd0, 5'd2, 7'h13}
                    : r < 6 ? 32'h00008067
                    : r < 8 ? enc_j(o) : enc_b(o);
        end
        for (int i = 0; i < 8; i++) begin
            kind[i] = 0;
            off[i]  = 0;
            mem[i]  = {12'(i + 1), 5'd0, 3'd0, 5'd1, 7'h13};
        end
        kind[4] = 1; off[4] = 8;  mem[4] = 32'h0080006F;
        kind[8] = 2; off[8] = -8; mem[8] = 32'hFE000CE3;

        rst = 1'b1; rdy = 1'b1; wrong_commit = 1'b0; commit_pc = '0;
        bp_upd_valid = 1'b0; bp_upd_pc = '0; bp_upd_taken = 1'b0; issue_stall = 1'b0;
        repeat (3) step();
        chk("rst_req_valid", ic_req_valid, 0);
        chk("rst_req_addr", ic_req_addr, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_jump", if_jump, 0);
        rst = 1'b0;
        reset_model(32'h0);

        run_pops(6, 100, 0);
        run_pops(40, 2000, 1);

        issue_stall = 1'b1;
        repeat (80) step();
        chk("iq_full", req_idx - pop_idx, 16);
        chk("iq_full_valid", if_valid, 1);
        repeat (10) begin
            step();
            chk("no_req_when_full", ic_req_valid, 0);
        end
        chk("head_hold", if_pc, e_pc[pop_idx]);
        issue_stall = 1'b0;
        p0 = pop_idx;
        repeat (16) step();
        chk("drain_rate", pop_idx - p0, 16);

        issue_stall = 1'b1;
        wait_req("flush_setup_req");
        wrong_commit = 1'b1;
        commit_pc    = 32'h100;
        step();
        wrong_commit = 1'b0;
        issue_stall  = 1'b0;
        reset_model(32'h100);
        chk("flush_if_valid", if_valid, 0);
        chk("flush_req_valid", ic_req_valid, 0);
        wait_req("flush_req_seen");
        chk("flush_req_addr", ic_req_addr, 32'h100);
        run_pops(6, 200, 0);

        wrong_commit = 1'b1; commit_pc = 32'h20;
        bp_upd_valid = 1'b1; bp_upd_pc = 32'h20; bp_upd_taken = 1'b1;
        step();
        bht_update(32'h20, 1'b1);
        step();
        bht_update(32'h20, 1'b1);
        wrong_commit = 1'b0; bp_upd_valid = 1'b0;
        reset_model(32'h20);
        p0 = 0;
        while (!if_valid && p0 < 50) begin
            step();
            p0++;
        end
        chk("bht_head_pc", if_pc, 32'h20);
`ifdef BHT_PREDICT_EN
        chk("bht_head_jump", if_jump, 1);
`else
        chk("bht_head_jump", if_jump, 0);
`endif
        run_pops(8, 200, 0);

        wait_req("rdy_setup_req");
        step();
        rdy = 1'b0;
        p0  = pop_idx;
        repeat (5) begin
            step();
            chk("rdy_hold_resp", ic_resp_valid, 1);
            chk("rdy_hold_req", ic_req_valid, 0);
        end
        chk("rdy_hold_pops", pop_idx, p0);
        rdy = 1'b1;
        run_pops(6, 200, 0);

        wait_req("rst_wait_req");
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) ctr[i] = 1;
        reset_model(32'h0);
        chk("midrst_if_valid", if_valid, 0);
        chk("midrst_req_valid", ic_req_valid, 0);
        run_pops(20, 1000, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
